tick_scheduler: RTL and testbench

//   Multiplexes the 10 ms Rollover tick into NUM_CH independent software timers.

---
 rtl/tick_scheduler_if.sv | 35 +++
 rtl/tick_scheduler.sv | 137 +++++++++++++
 tb/tb_tick_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// Bus bundle for tick_scheduler: tick input, channel configuration, acknowledge
// and the expiry/status outputs. Clock and reset stay outside the bundle.
`timescale 1ns/1ps

interface tick_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 8
);
    logic              tick;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_periodic;
    logic              cfg_stop;
    logic              ack_valid;
    logic [IDX_W-1:0]  ack_ch;
    logic [NUM_CH-1:0] expire;
    logic [NUM_CH-1:0] pending;
    logic              busy;
    logic              overrun;

    modport master (
        output tick, cfg_valid, cfg_ch, cfg_period, cfg_periodic, cfg_stop,
               ack_valid, ack_ch,
        input  cfg_ready, expire, pending, busy, overrun
    );

    modport slave (
        input  tick, cfg_valid, cfg_ch, cfg_period, cfg_periodic, cfg_stop,
               ack_valid, ack_ch,
        output cfg_ready, expire, pending, busy, overrun
    );
endinterface

// File: rtl/tick_scheduler.sv
// NUM_CH software timers driven by the 10 ms tick, serviced by one shared
// decrementer that a scan FSM walks across the channels, one per clock.
`timescale 1ns/1ps

module tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 8
) (
    input logic             clk,
    input logic             Reset,
    tick_scheduler_if.slave bus
);
    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_tick_pend;
    logic              r_overrun;
    logic [NUM_CH-1:0] r_expire;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_armed;
    logic [NUM_CH-1:0] r_periodic;
    logic [CNT_W-1:0]  r_period [NUM_CH];
    logic [CNT_W-1:0]  r_count  [NUM_CH];

    logic              w_cfg_ready;
    logic              w_cfg_fire;
    logic              w_cfg_disarm;
    logic              w_last;
    logic              w_scan_armed;
    logic              w_scan_hit;
    logic [CNT_W-1:0]  w_scan_cnt;
    logic [NUM_CH-1:0] w_pending_nxt;

    assign w_cfg_ready  = (r_state == S_IDLE) && !bus.tick && !r_tick_pend;
    assign w_cfg_fire   = bus.cfg_valid && w_cfg_ready;
    assign w_cfg_disarm = bus.cfg_stop || (bus.cfg_period == '0);
    assign w_last       = (r_idx == IDX_W'(NUM_CH - 1));
    assign w_scan_armed = (r_state == S_SCAN) && r_armed[r_idx];
    assign w_scan_cnt   = r_count[r_idx];
    assign w_scan_hit   = w_scan_armed && (w_scan_cnt == CNT_W'(1));

    // Expiry set is applied after the ack clear so a same-cycle set wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (bus.ack_valid) begin
            w_pending_nxt[bus.ack_ch] = 1'b0;
        end
        if (w_scan_hit) begin
            w_pending_nxt[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
            r_expire    <= '0;
            r_pending   <= '0;
            r_armed     <= '0;
            r_periodic  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_period[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_expire  <= '0;
            r_pending <= w_pending_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.tick || r_tick_pend) begin
                        r_state     <= S_SCAN;
                        r_idx       <= '0;
                        r_tick_pend <= 1'b0;
                    end else if (w_cfg_fire) begin
                        if (w_cfg_disarm) begin
                            r_armed[bus.cfg_ch] <= 1'b0;
                            r_count[bus.cfg_ch] <= '0;
                        end else begin
                            r_armed[bus.cfg_ch]    <= 1'b1;
                            r_periodic[bus.cfg_ch] <= bus.cfg_periodic;
                            r_period[bus.cfg_ch]   <= bus.cfg_period;
                            r_count[bus.cfg_ch]    <= bus.cfg_period;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_scan_hit) begin
                        r_expire[r_idx] <= 1'b1;
                        if (r_periodic[r_idx]) begin
                            r_count[r_idx] <= r_period[r_idx];
                        end else begin
                            r_armed[r_idx] <= 1'b0;
                        end
                    end else if (w_scan_armed) begin
                        r_count[r_idx] <= w_scan_cnt - CNT_W'(1);
                    end

                    // The one-deep slot is consumed by the restart on the last
                    // channel; a tick landing while it is still full is lost.
                    if (w_last && r_tick_pend) begin
                        r_tick_pend <= 1'b0;
                        if (bus.tick) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (bus.tick) begin
                        if (r_tick_pend) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_tick_pend <= 1'b1;
                        end
                    end

                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= r_tick_pend ? S_SCAN : S_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.expire    = r_expire;
    assign bus.pending   = r_pending;
    assign bus.busy      = (r_state == S_SCAN);
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: table of single-channel scenarios plus hand-built
// corner sequences; every expire cycle is checked against a scoreboard queue.
`timescale 1ns/1ps

module tb_tick_scheduler;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic Reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tick_scheduler_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    tick_scheduler #(.NUM_CH(NUM_CH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int                cyc;
        logic [NUM_CH-1:0] mask;
    } exp_t;

    typedef struct {
        int ch;
        int period;
        bit periodic;
        bit stop;
        int nticks;
        int exp_pulses;
        bit exp_pend;
    } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses[NUM_CH];
    bit   mon_en = 1'b0;

    bit   m_armed[NUM_CH];
    bit   m_per[NUM_CH];
    int   m_period[NUM_CH];
    int   m_count[NUM_CH];
    int   m_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_armed[i]  = 1'b0;
            m_per[i]    = 1'b0;
            m_period[i] = 0;
            m_count[i]  = 0;
        end
        m_s = -100;
    endtask

    // Tick driven in cycle c; works out which scan serves it, then predicts.
    task automatic model_tick(input int c);
        int s;
        logic [NUM_CH-1:0] mk;
        if (c > m_s + NUM_CH) s = c;
        else if (c <= m_s) return;
        else if (c == m_s + NUM_CH) s = c + 1;
        else s = m_s + NUM_CH;
        m_s = s;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_armed[i]) begin
                if (m_count[i] == 1) begin
                    mk = '0;
                    mk[i] = 1'b1;
                    sbq.push_back('{s + 2 + i, mk});
                    if (m_per[i]) m_count[i] = m_period[i];
                    else m_armed[i] = 1'b0;
                end else begin
                    m_count[i]--;
                end
            end
        end
    endtask

    task automatic drive_idle();
        bus.tick         = 1'b0;
        bus.cfg_valid    = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_period   = '0;
        bus.cfg_periodic = 1'b0;
        bus.cfg_stop     = 1'b0;
        bus.ack_valid    = 1'b0;
        bus.ack_ch       = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        sbq.delete();
        model_clear();
    endtask

    task automatic do_cfg(input int ch, input int p, input bit per, input bit stp, output int acc);
        int n = 0;
        bus.cfg_ch       = IDX_W'(ch);
        bus.cfg_period   = CNT_W'(p);
        bus.cfg_periodic = per;
        bus.cfg_stop     = stp;
        bus.cfg_valid    = 1'b1;
        while (bus.cfg_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("cfg_accept", bus.cfg_ready, 1);
        acc = cyc;
        step();
        bus.cfg_valid = 1'b0;
        if (stp || p == 0) begin
            m_armed[ch] = 1'b0;
            m_count[ch] = 0;
        end else begin
            m_armed[ch]  = 1'b1;
            m_per[ch]    = per;
            m_period[ch] = p;
            m_count[ch]  = p;
        end
    endtask

    task automatic cfg(input int ch, input int p, input bit per, input bit stp);
        int acc;
        do_cfg(ch, p, per, stp, acc);
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        model_tick(cyc);
        step();
        bus.tick = 1'b0;
    endtask

    task automatic ack(input int ch);
        bus.ack_valid = 1'b1;
        bus.ack_ch    = IDX_W'(ch);
        step();
        bus.ack_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int   t0;
        int   acc;
        int   base;

        vt[0] = '{0, 3,   1'b0, 1'b0, 4,   1, 1'b1};
        vt[1] = '{2, 2,   1'b1, 1'b0, 6,   3, 1'b1};
        vt[2] = '{1, 1,   1'b1, 1'b0, 5,   5, 1'b1};
        vt[3] = '{3, 0,   1'b1, 1'b0, 5,   0, 1'b0};
        vt[4] = '{1, 5,   1'b0, 1'b1, 6,   0, 1'b0};
        vt[5] = '{3, 4,   1'b0, 1'b0, 3,   0, 1'b0};
        vt[6] = '{2, 255, 1'b0, 1'b0, 255, 1, 1'b1};
        vt[7] = '{0, 4,   1'b1, 1'b0, 12,  3, 1'b1};

        for (int i = 0; i < NUM_CH; i++) pulses[i] = 0;

        fork
            forever begin
                logic [NUM_CH-1:0] m;
                @(negedge clk);
                if (mon_en) begin
                    m = '0;
                    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                        if (sbq[0].cyc == cyc) m |= sbq[0].mask;
                        void'(sbq.pop_front());
                    end
                    chk("expire", bus.expire, m);
                    for (int i = 0; i < NUM_CH; i++) if (bus.expire[i] === 1'b1) pulses[i]++;
                end
            end
        join_none

        // Reset state
        do_reset();
        chk("rst_expire", bus.expire, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
        mon_en = 1'b1;

        // Single-channel scenarios
        for (int v = 0; v < 8; v++) begin
            do_reset();
            cfg(vt[v].ch, vt[v].period, vt[v].periodic, vt[v].stop);
            base = pulses[vt[v].ch];
            for (int k = 0; k < vt[v].nticks; k++) begin
                tick_once();
                idle_cycles(8);
            end
            idle_cycles(4);
            chk($sformatf("vec%0d_pulses", v), pulses[vt[v].ch] - base, vt[v].exp_pulses);
            chk($sformatf("vec%0d_pending", v), bus.pending,
                vt[v].exp_pend ? (32'd1 << vt[v].ch) : 32'd0);
        end

        // All channels period 1: staggered expiry, busy window
        do_reset();
        for (int c = 0; c < NUM_CH; c++) cfg(c, 1, 1'b0, 1'b0);
        t0 = cyc;
        tick_once();
        for (int k = 1; k <= NUM_CH; k++) begin
            chk($sformatf("all_busy_T+%0d", k), bus.busy, 1);
            chk($sformatf("all_nready_T+%0d", k), bus.cfg_ready, 0);
            step();
        end
        chk("all_busy_end", bus.busy, 0);
        chk("all_ready_end", bus.cfg_ready, 1);
        idle_cycles(2);
        chk("all_pending", bus.pending, 4'hF);

        // Ticks at T, T+2, T+3: back-to-back rescan, overrun, config hold-off
        do_reset();
        cfg(0, 1, 1'b1, 1'b0);
        t0 = cyc;
        tick_once();
        step();
        bus.tick = 1'b1;
        model_tick(cyc);
        step();
        model_tick(cyc);
        step();
        bus.tick = 1'b0;
        chk("ovr_busy_T+4", bus.busy, 1);
        chk("ovr_overrun", bus.overrun, 1);
        do_cfg(2, 1, 1'b0, 1'b0, acc);
        chk("ovr_cfg_holdoff", acc - t0, 9);
        tick_once();
        idle_cycles(8);
        chk("ovr_sticky", bus.overrun, 1);
        chk("ovr_pending", bus.pending, 4'b0101);
        do_reset();
        chk("ovr_cleared", bus.overrun, 0);

        // Ack racing an expiry, ack of idle channel, re-arm overwrite
        cfg(0, 1, 1'b0, 1'b0);
        cfg(1, 1, 1'b0, 1'b0);
        tick_once();
        step();
        ack(1);
        chk("ack_race", bus.pending, 4'b0011);
        ack(3);
        chk("ack_nonpend", bus.pending, 4'b0011);
        ack(1);
        chk("ack_clear", bus.pending, 4'b0001);
        cfg(0, 0, 1'b0, 1'b1);
        chk("cfg_keeps_pending", bus.pending, 4'b0001);
        cfg(2, 5, 1'b1, 1'b0);
        tick_once();
        idle_cycles(8);
        cfg(2, 2, 1'b0, 1'b0);
        base = pulses[2];
        for (int k = 0; k < 3; k++) begin
            tick_once();
            idle_cycles(8);
        end
        chk("rearm_pulses", pulses[2] - base, 1);

        // Reset in cycle T+2 of a scan
        do_reset();
        for (int c = 0; c < 3; c++) cfg(c, 1, 1'b1, 1'b0);
        cfg(3, 0, 1'b1, 1'b0);
        t0 = cyc;
        bus.tick = 1'b1;
        sbq.push_back('{t0 + 2, 4'b0001});
        step();
        bus.tick = 1'b0;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        model_clear();
        chk("mid_rst_expire", bus.expire, 0);
        chk("mid_rst_pending", bus.pending, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_overrun", bus.overrun, 0);
        chk("mid_rst_ready", bus.cfg_ready, 1);
        idle_cycles(6);
        tick_once();
        idle_cycles(8);
        chk("post_rst_pending", bus.pending, 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
